// File: rtl/rename_flow_ctrl_if.sv
// Handshake and status bundle between decode/commit and the
// rename flow controller.
interface rename_flow_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             flush_req;
  logic             commit_busy;
  logic             allocatable;
  logic             rob_full;
  logic             iq_full;
  logic             dec_valid;
  logic             dec_ready;
  logic             rename_fire;
  logic             pause_rename;
  logic             recover;
  logic             frontend_flush;
  logic             busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output flush_req, commit_busy, allocatable,
    output rob_full, iq_full, dec_valid,
    input  dec_ready, rename_fire, pause_rename,
    input  recover, frontend_flush, busy, stall_cnt
  );

  modport slave (
    input  flush_req, commit_busy, allocatable,
    input  rob_full, iq_full, dec_valid,
    output dec_ready, rename_fire, pause_rename,
    output recover, frontend_flush, busy, stall_cnt
  );
endinterface

// File: rtl/rename_flow_ctrl.sv
// Rename stage sequencer: run/drain/recover/resume flush flow
// plus a saturating rename-stall counter.
module rename_flow_ctrl #(
  parameter int RECOVER_CYCLES = 2,
  parameter int CNT_W          = 32
) (
  input  logic               clk,
  input  logic               rst,
  rename_flow_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_RECOVER,
    S_RESUME
  } state_e;

  localparam logic [3:0] LP_LOAD = 4'(RECOVER_CYCLES - 1);

  state_e           r_state;
  state_e           w_next;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic             r_recover;
  logic             r_fflush;
  logic             w_fflush_nxt;
  logic [CNT_W-1:0] r_stall;
  logic             w_pause_run;
  logic             w_pause;
  logic             w_ready;
  logic             w_stall_inc;

  assign w_pause_run = bus.rob_full | bus.iq_full
                     | ~bus.allocatable;

  always_comb begin
    w_next       = r_state;
    w_cnt_nxt    = r_cnt;
    w_pause      = 1'b1;
    w_ready      = 1'b0;
    w_fflush_nxt = 1'b0;
    unique case (1'b1)
      (r_state == S_RUN): begin
        w_pause = w_pause_run;
        w_ready = ~w_pause_run & ~bus.flush_req;
        if (bus.flush_req) begin
          w_next       = S_DRAIN;
          w_fflush_nxt = 1'b1;
        end
      end
      (r_state == S_DRAIN): begin
        // a flush here is already covered by the one in flight
        if (!bus.commit_busy) begin
          w_next    = S_RECOVER;
          w_cnt_nxt = LP_LOAD;
        end
      end
      (r_state == S_RECOVER): begin
        if (bus.flush_req) begin
          w_next       = S_DRAIN;
          w_cnt_nxt    = 4'd0;
          w_fflush_nxt = 1'b1;
        end else if (r_cnt == 4'd0) begin
          w_next = S_RESUME;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      (r_state == S_RESUME): begin
        if (bus.flush_req) begin
          w_next       = S_DRAIN;
          w_fflush_nxt = 1'b1;
        end else begin
          w_next = S_RUN;
        end
      end
      default: begin
        w_next    = S_RUN;
        w_cnt_nxt = 4'd0;
      end
    endcase
  end

  assign w_stall_inc = (r_state == S_RUN) & bus.dec_valid
                     & ~w_ready & ~(&r_stall);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_RUN;
      r_cnt     <= 4'd0;
      r_recover <= 1'b0;
      r_fflush  <= 1'b0;
      r_stall   <= '0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt_nxt;
      r_recover <= (w_next == S_RECOVER);
      r_fflush  <= w_fflush_nxt;
      if (w_stall_inc) begin
        r_stall <= r_stall + 1'b1;
      end
    end
  end

  assign bus.dec_ready      = w_ready;
  assign bus.rename_fire    = bus.dec_valid & w_ready;
  assign bus.pause_rename   = w_pause;
  assign bus.recover        = r_recover;
  assign bus.frontend_flush = r_fflush;
  assign bus.busy           = (r_state != S_RUN);
  assign bus.stall_cnt      = r_stall;

endmodule

// File: tb/tb_rename_flow_ctrl.sv
// Bench for rename_flow_ctrl: vector table, corner sequences
// and random traffic against a phase-level reference model.
module tb_rename_flow_ctrl;

  localparam int RC = 2;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  localparam int M_RUN = 0;
  localparam int M_DRAIN = 1;
  localparam int M_REC = 2;
  localparam int M_RES = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rename_flow_ctrl_if #(.CNT_W(CW)) bus();

  rename_flow_ctrl #(
    .RECOVER_CYCLES(RC),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit r, fl, cb, al, rf, iq, dv, chk;
    bit fire, rdy, pau, rec, ff, busy;
    int stall;
  } vec_t;

  vec_t vq[$];

  int errors = 0;
  int checks = 0;

  bit i_rst, i_fl, i_cb, i_al, i_rf, i_iq, i_dv;
  bit s_fire, s_rdy, s_pau, s_rec, s_ff, s_busy;
  int s_stall;
  bit prev_ff = 1'b0;

  int m_mode = M_RUN;
  int m_left = 0;
  int m_stall = 0;
  bit m_ff = 1'b0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic drive(bit r, bit fl, bit cb, bit al,
                       bit rf, bit iq, bit dv);
    i_rst = r; i_fl = fl; i_cb = cb; i_al = al;
    i_rf = rf; i_iq = iq; i_dv = dv;
    rst = r;
    bus.flush_req = fl;
    bus.commit_busy = cb;
    bus.allocatable = al;
    bus.rob_full = rf;
    bus.iq_full = iq;
    bus.dec_valid = dv;
  endtask

  task automatic sample();
    @(negedge clk);
    s_fire = bus.rename_fire;
    s_rdy = bus.dec_ready;
    s_pau = bus.pause_rename;
    s_rec = bus.recover;
    s_ff = bus.frontend_flush;
    s_busy = bus.busy;
    s_stall = int'(bus.stall_cnt);
  endtask

  task automatic invariants();
    chk("inv_rec_fire", int'(s_rec & s_fire), 0);
    chk("inv_ff_twice", int'(s_ff & prev_ff), 0);
    prev_ff = s_ff;
  endtask

  task automatic model_cmp();
    bit p, rdy;
    p = (m_mode == M_RUN) ? (i_rf | i_iq | ~i_al) : 1'b1;
    rdy = (m_mode == M_RUN) && !p && !i_fl;
    chk("pause_rename", s_pau, p);
    chk("dec_ready", s_rdy, rdy);
    chk("rename_fire", s_fire, i_dv & rdy);
    chk("recover", s_rec, m_mode == M_REC);
    chk("busy", s_busy, m_mode != M_RUN);
    chk("frontend_flush", s_ff, m_ff);
    chk("stall_cnt", s_stall, m_stall);
  endtask

  task automatic adv();
    bit p, rdy;
    @(posedge clk);
    p = (m_mode == M_RUN) ? (i_rf | i_iq | ~i_al) : 1'b1;
    rdy = (m_mode == M_RUN) && !p && !i_fl;
    if (i_rst) begin
      m_mode = M_RUN; m_left = 0; m_stall = 0; m_ff = 0;
    end else begin
      if (m_mode == M_RUN && i_dv && !rdy && m_stall < SAT)
        m_stall++;
      m_ff = i_fl && (m_mode != M_DRAIN);
      case (m_mode)
        M_RUN: if (i_fl) m_mode = M_DRAIN;
        M_DRAIN: if (!i_cb) begin
          m_mode = M_REC; m_left = RC;
        end
        M_REC: if (i_fl) m_mode = M_DRAIN;
               else begin
                 m_left--;
                 if (m_left == 0) m_mode = M_RES;
               end
        default: m_mode = i_fl ? M_DRAIN : M_RUN;
      endcase
    end
    #1;
  endtask

  task automatic step();
    sample();
    model_cmp();
    invariants();
    adv();
  endtask

  task automatic cyc(bit fl, bit cb, bit dv);
    drive(1'b0, fl, cb, 1'b1, 1'b0, 1'b0, dv);
    step();
  endtask

  task automatic add(bit r, bit fl, bit cb, bit al, bit rf,
                     bit iq, bit dv, bit c, bit fire, bit rdy,
                     bit pau, bit rec, bit ff, bit busy, int st);
    vec_t v;
    v.r = r; v.fl = fl; v.cb = cb; v.al = al; v.rf = rf;
    v.iq = iq; v.dv = dv; v.chk = c; v.fire = fire;
    v.rdy = rdy; v.pau = pau; v.rec = rec; v.ff = ff;
    v.busy = busy; v.stall = st;
    vq.push_back(v);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    add(1,0,0,1,0,0,0,0, 0,0,0,0,0,0,0);
    add(1,0,0,1,0,0,0,1, 0,1,0,0,0,0,0);
    for (int i = 0; i < 10; i++)
      add(0,0,0,1,0,0,1,1, 1,1,0,0,0,0,0);
    for (int i = 0; i < 3; i++)
      add(0,0,0,0,0,0,1,1, 0,0,1,0,0,0,i);
    for (int i = 0; i < 2; i++)
      add(0,0,0,1,1,0,1,1, 0,0,1,0,0,0,3+i);
    add(0,0,0,1,0,0,1,1, 1,1,0,0,0,0,5);
    add(0,1,0,1,0,0,1,1, 0,0,0,0,0,0,5);
    add(0,0,0,1,0,0,1,1, 0,0,1,0,1,1,6);
    add(0,0,0,1,0,0,1,1, 0,0,1,1,0,1,6);
    add(0,0,0,1,0,0,1,1, 0,0,1,1,0,1,6);
    add(0,0,0,1,0,0,1,1, 0,0,1,0,0,1,6);
    add(0,0,0,1,0,0,1,1, 1,1,0,0,0,0,6);
    add(0,0,0,1,0,1,1,1, 0,0,1,0,0,0,6);
    add(0,0,0,1,0,0,1,1, 1,1,0,0,0,0,7);

    foreach (vq[i]) begin
      drive(vq[i].r, vq[i].fl, vq[i].cb, vq[i].al,
            vq[i].rf, vq[i].iq, vq[i].dv);
      sample();
      if (vq[i].chk) begin
        chk($sformatf("v%0d_fire", i), s_fire, vq[i].fire);
        chk($sformatf("v%0d_rdy", i), s_rdy, vq[i].rdy);
        chk($sformatf("v%0d_pause", i), s_pau, vq[i].pau);
        chk($sformatf("v%0d_rec", i), s_rec, vq[i].rec);
        chk($sformatf("v%0d_ff", i), s_ff, vq[i].ff);
        chk($sformatf("v%0d_busy", i), s_busy, vq[i].busy);
        chk($sformatf("v%0d_stall", i), s_stall, vq[i].stall);
        invariants();
      end
      adv();
    end

    // flush held off by commit_busy for five cycles
    cyc(1, 1, 1);
    chk("t4_flush_fire", s_fire, 0);
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 1, 1);
      chk("t4_drain_rec", s_rec, 0);
      chk("t4_drain_busy", s_busy, 1);
    end
    cyc(0, 0, 1); chk("t4_last_drain", s_rec, 0);
    cyc(0, 0, 1); chk("t4_rec1", s_rec, 1);
    cyc(0, 0, 1); chk("t4_rec2", s_rec, 1);
    cyc(0, 0, 1); chk("t4_resume_rec", s_rec, 0);
    chk("t4_resume_busy", s_busy, 1);
    cyc(0, 0, 1); chk("t4_run_fire", s_fire, 1);

    // re-flush during the second recover cycle
    cyc(1, 0, 1);
    cyc(0, 0, 1); chk("t5_ff1", s_ff, 1);
    cyc(0, 0, 1); chk("t5_rec_a", s_rec, 1);
    cyc(1, 0, 1); chk("t5_rec_b", s_rec, 1);
    cyc(0, 0, 1); chk("t5_drop", s_rec, 0);
    chk("t5_ff2", s_ff, 1);
    chk("t5_busy", s_busy, 1);
    cyc(0, 0, 1); chk("t5_rec_c", s_rec, 1);
    cyc(0, 0, 1); chk("t5_rec_d", s_rec, 1);
    cyc(0, 0, 1); chk("t5_resume", s_rec, 0);
    cyc(0, 0, 1); chk("t5_run_fire", s_fire, 1);

    // reset during recover, then saturate the stall counter
    cyc(1, 0, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    chk("t6_rec_at_rst", s_rec, 1);
    cyc(0, 0, 1);
    chk("t6_rec", s_rec, 0);
    chk("t6_busy", s_busy, 0);
    chk("t6_stall", s_stall, 0);
    chk("t6_fire", s_fire, 1);
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
    end
    sample();
    chk("t6_sat", s_stall, SAT);
    adv();

    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(199) == 0,
            $urandom_range(11) == 0,
            $urandom_range(1) == 1,
            $urandom_range(5) != 0,
            $urandom_range(7) == 0,
            $urandom_range(7) == 0,
            $urandom_range(3) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
